// File: rtl/response_misr_collector.sv
// Response-side signature collector: folds each qualified sample of a wide DUT
// output bus into a MISR and presents the final signature after NUM_VECTORS
// captures over a valid/ready handshake.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   start      - one-cycle pulse that begins a run (honoured only in IDLE)
//   y          - DUT response bus (Y_WIDTH bits)
//   y_valid    - qualifies y for capture this cycle
//   sig_out    - current or final signature (SIG_WIDTH bits)
//   sig_valid  - final signature available
//   sig_ready  - consumer accepts the signature
//   busy       - high while capturing
//   vec_count  - samples captured in the current run
module response_misr_collector #(
   parameter int unsigned             Y_WIDTH     = 151,
   parameter int unsigned             SIG_WIDTH   = 32,
   parameter logic [SIG_WIDTH-1:0]    POLY        = SIG_WIDTH'(32'h04C11DB7),
   parameter logic [SIG_WIDTH-1:0]    SEED        = SIG_WIDTH'(32'hFFFFFFFF),
   parameter int unsigned             NUM_VECTORS = 22
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [Y_WIDTH-1:0]   y,
   input  logic                 y_valid,
   output logic [SIG_WIDTH-1:0] sig_out,
   output logic                 sig_valid,
   input  logic                 sig_ready,
   output logic                 busy,
   output logic [15:0]          vec_count
);

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned N_CHUNK = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
   localparam int unsigned PAD_W   = N_CHUNK * SIG_WIDTH;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [SIG_WIDTH-1:0] sig_q, sig_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 valid_q, valid_d;
   logic [PAD_W-1:0]     y_pad;
   logic [SIG_WIDTH-1:0] fold;
   logic [SIG_WIDTH-1:0] sig_step;

   // Zero-pad y to a whole number of chunks and XOR the chunks together
   always_comb begin
      y_pad = PAD_W'(y);
      fold  = '0;
      for (int k = 0; k < int'(N_CHUNK); k++) begin
         fold = fold ^ y_pad[k*SIG_WIDTH +: SIG_WIDTH];
      end
   end

   // One MISR step: shift left, apply taps if the shifted-out MSB was set
   assign sig_step = {sig_q[SIG_WIDTH-2:0], 1'b0}
                   ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
                   ^ fold;

   // Next-state and registered-output decode
   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sig_d   = SEED;
               cnt_d   = '0;
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (y_valid) begin
               sig_d = sig_step;
               cnt_d = cnt_q + CNT_W'(1);
               // Last capture moves straight to DONE so sig_valid rises next cycle
               if (cnt_d == CNT_W'(NUM_VECTORS)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (valid_q && sig_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d  = (state_d == CAPTURE);
      valid_d = (state_d == DONE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sig_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign sig_out   = sig_q;
   assign sig_valid = valid_q;
   assign busy      = busy_q;
   assign vec_count = cnt_q;

endmodule

// File: tb/tb_response_misr_collector.sv
// Directed bench for response_misr_collector. Four instances with different
// NUM_VECTORS/SEED share one stimulus; each test resets and checks the
// instance whose configuration it targets.
module tb_response_misr_collector;

   localparam int unsigned YW = 151;
   localparam int unsigned SW = 32;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [YW-1:0] y;
   logic          y_valid;
   logic          sig_ready;

   logic [SW-1:0] sig_a, sig_b, sig_c, sig_d;
   logic          sv_a, sv_b, sv_c, sv_d;
   logic          bz_a, bz_b, bz_c, bz_d;
   logic [15:0]   vc_a, vc_b, vc_c, vc_d;

   int unsigned   n_vec;
   int unsigned   n_err;
   logic [SW-1:0] held;

   // N=1, SEED=all-ones: seed-only step, backpressure, back-to-back
   response_misr_collector #(.NUM_VECTORS(1), .SEED(32'hFFFFFFFF)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start), .y(y), .y_valid(y_valid),
      .sig_out(sig_a), .sig_valid(sv_a), .sig_ready(sig_ready),
      .busy(bz_a), .vec_count(vc_a));

   // N=2, SEED=0: fold check
   response_misr_collector #(.NUM_VECTORS(2), .SEED(32'h0)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start), .y(y), .y_valid(y_valid),
      .sig_out(sig_b), .sig_valid(sv_b), .sig_ready(sig_ready),
      .busy(bz_b), .vec_count(vc_b));

   // N=3, SEED=0: valid gaps and ignored start
   response_misr_collector #(.NUM_VECTORS(3), .SEED(32'h0)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start), .y(y), .y_valid(y_valid),
      .sig_out(sig_c), .sig_valid(sv_c), .sig_ready(sig_ready),
      .busy(bz_c), .vec_count(vc_c));

   // Default parameters: reset state and reset mid-run
   response_misr_collector u_d (
      .clk(clk), .rst_n(rst_n), .start(start), .y(y), .y_valid(y_valid),
      .sig_out(sig_d), .sig_valid(sv_d), .sig_ready(sig_ready),
      .busy(bz_d), .vec_count(vc_d));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #7;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      y         = '0;
      y_valid   = 1'b0;
      sig_ready = 1'b0;
      #3;

      // Reset state
      check("rst_sig",   64'(sig_d), 64'h0);
      check("rst_valid", 64'(sv_d),  64'h0);
      check("rst_busy",  64'(bz_d),  64'h0);
      check("rst_cnt",   64'(vc_d),  64'h0);
      rst_n = 1'b1;
      tick();

      // Reset mid-run on the default instance
      start = 1'b1;
      tick();
      start = 1'b0;
      check("mid_busy", 64'(bz_d), 64'h1);
      check("mid_seed", 64'(sig_d), 64'hFFFFFFFF);
      y_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         y = YW'(64'h1234_5678_9ABC_DEF0 + 64'(i));
         tick();
      end
      y_valid = 1'b0;
      check("mid_cnt5", 64'(vc_d), 64'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_sig",  64'(sig_d), 64'h0);
      check("mid_rst_busy", 64'(bz_d),  64'h0);
      check("mid_rst_cnt",  64'(vc_d),  64'h0);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mid_no_valid", 64'(sv_d), 64'h0);
      end

      // Seed-only step (N=1); y_valid in the start cycle must be ignored
      do_reset();
      start   = 1'b1;
      y       = '0;
      y_valid = 1'b1;
      tick();
      start = 1'b0;
      check("seed_start_cnt",  64'(vc_a),  64'd0);
      check("seed_start_sig",  64'(sig_a), 64'hFFFFFFFF);
      check("seed_start_busy", 64'(bz_a),  64'h1);
      tick();
      y_valid = 1'b0;
      check("seed_valid", 64'(sv_a),  64'h1);
      check("seed_sig",   64'(sig_a), 64'hFB3EE249);
      check("seed_cnt",   64'(vc_a),  64'd1);
      check("seed_busy",  64'(bz_a),  64'h0);

      // Backpressure: hold DONE for 10 cycles while toggling y, y_valid, start
      held = sig_a;
      for (int i = 0; i < 10; i++) begin
         y       = ~y;
         y_valid = 1'b1;
         start   = ~start;
         tick();
         check("bp_valid", 64'(sv_a),  64'h1);
         check("bp_sig",   64'(sig_a), 64'(held));
         check("bp_cnt",   64'(vc_a),  64'd1);
      end
      // Acceptance with a coincident start: start is ignored
      y_valid   = 1'b0;
      sig_ready = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check("acc_valid", 64'(sv_a),  64'h0);
      check("acc_busy",  64'(bz_a),  64'h0);
      check("acc_sig",   64'(sig_a), 64'hFB3EE249);
      tick();
      check("acc_idle_busy", 64'(bz_a), 64'h0);

      // Back-to-back run: SEED reload and vec_count clear
      sig_ready = 1'b0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check("b2b_seed", 64'(sig_a), 64'hFFFFFFFF);
      check("b2b_cnt0", 64'(vc_a),  64'd0);
      y       = '0;
      y_valid = 1'b1;
      tick();
      y_valid = 1'b0;
      check("b2b_sig",   64'(sig_a), 64'hFB3EE249);
      check("b2b_valid", 64'(sv_a),  64'h1);
      check("b2b_cnt",   64'(vc_a),  64'd1);

      // Fold check (N=2, SEED=0)
      do_reset();
      start = 1'b1;
      tick();
      start   = 1'b0;
      y       = YW'(1);
      y_valid = 1'b1;
      tick();
      check("fold_first", 64'(sig_b), 64'h1);
      check("fold_nv",    64'(sv_b),  64'h0);
      y = YW'(1) << 32;
      tick();
      y_valid = 1'b0;
      check("fold_sig",   64'(sig_b), 64'h3);
      check("fold_valid", 64'(sv_b),  64'h1);
      check("fold_cnt",   64'(vc_b),  64'd2);
      sig_ready = 1'b1;
      tick();
      sig_ready = 1'b0;
      start     = 1'b1;
      tick();
      start   = 1'b0;
      y       = YW'(1) << 150;
      y_valid = 1'b1;
      tick();
      y_valid = 1'b0;
      check("fold_top",     64'(sig_b), 64'h00400000);
      check("fold_top_cnt", 64'(vc_b),  64'd1);

      // Valid gaps and start during capture (N=3, SEED=0, y=1)
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      y     = YW'(1);
      y_valid = 1'b1; tick();
      check("gap_s1", 64'(sig_c), 64'h1);
      y_valid = 1'b0; tick();
      y_valid = 1'b0; start = 1'b1; tick();
      check("gap_hold_sig", 64'(sig_c), 64'h1);
      check("gap_hold_cnt", 64'(vc_c),  64'd1);
      y_valid = 1'b1; start = 1'b1; tick();
      check("gap_s2", 64'(sig_c), 64'h3);
      y_valid = 1'b0; start = 1'b0; tick();
      y_valid = 1'b1; tick();
      y_valid = 1'b0;
      check("gap_sig",   64'(sig_c), 64'h7);
      check("gap_cnt",   64'(vc_c),  64'd3);
      check("gap_valid", 64'(sv_c),  64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
